// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of one single-outstanding memory port.
// Optional round-robin conflict resolution is enabled by defining MEM_ARBITER_RR_EN.
module mem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk_i,
    input  logic                rst_ni,

    input  logic                if_req_valid_i,
    output logic                if_req_ready_o,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_rsp_valid_o,
    output logic [DATA_W-1:0]   if_rdata_o,

    input  logic                ls_req_valid_i,
    output logic                ls_req_ready_o,
    input  logic [ADDR_W-1:0]   ls_addr_i,
    input  logic                ls_wen_i,
    input  logic [DATA_W-1:0]   ls_wdata_i,
    input  logic [DATA_W/8-1:0] ls_wmask_i,
    output logic                ls_rsp_valid_o,
    output logic [DATA_W-1:0]   ls_rdata_o,

    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic                mem_wen_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wmask_o,
    input  logic                mem_rsp_valid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,

    output logic                busy_o,
    output logic                err_spurious_o
);

    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP
    } state_e;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } owner_e;

    state_e              state_q;
    owner_e              owner_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                wen_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [MASK_W-1:0]   wmask_q;
    logic                busy_q;
    logic                mem_req_valid_q;
    logic                err_q;
`ifdef MEM_ARBITER_RR_EN
    owner_e              last_grant_q;
`endif

    logic                grant_valid;
    logic                ls_wins;
    owner_e              owner_d;
    logic [ADDR_W-1:0]   addr_d;
    logic                wen_d;
    logic [DATA_W-1:0]   wdata_d;
    logic [MASK_W-1:0]   wmask_d;
    logic                rsp_fire;

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        grant_valid = 1'b0;
        ls_wins     = 1'b0;
        // Ready is gated by reset so no output can rise while rst_ni is low.
        if (rst_ni && (state_q == ST_IDLE)) begin
            grant_valid = if_req_valid_i || ls_req_valid_i;
`ifdef MEM_ARBITER_RR_EN
            ls_wins = ls_req_valid_i && (!if_req_valid_i || (last_grant_q == OWN_IF));
`else
            ls_wins = ls_req_valid_i;
`endif
        end

        owner_d = ls_wins ? OWN_LS : OWN_IF;
        addr_d  = ls_wins ? ls_addr_i : if_addr_i;
        wen_d   = ls_wins && ls_wen_i;
        wdata_d = ls_wins ? ls_wdata_i : '0;
        wmask_d = ls_wins ? ls_wmask_i : '0;
    end

    assign rsp_fire = (state_q == ST_RESP) && mem_rsp_valid_i;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= ST_IDLE;
            owner_q         <= OWN_IF;
            addr_q          <= '0;
            wen_q           <= 1'b0;
            wdata_q         <= '0;
            wmask_q         <= '0;
            busy_q          <= 1'b0;
            mem_req_valid_q <= 1'b0;
            err_q           <= 1'b0;
`ifdef MEM_ARBITER_RR_EN
            last_grant_q    <= OWN_LS;
`endif
        end else begin
            // Any response outside RESP has no owner; flag it until the next reset.
            if (mem_rsp_valid_i && (state_q != ST_RESP)) begin
                err_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (grant_valid) begin
                        state_q         <= ST_REQ;
                        owner_q         <= owner_d;
                        addr_q          <= addr_d;
                        wen_q           <= wen_d;
                        wdata_q         <= wdata_d;
                        wmask_q         <= wmask_d;
                        busy_q          <= 1'b1;
                        mem_req_valid_q <= 1'b1;
`ifdef MEM_ARBITER_RR_EN
                        last_grant_q    <= owner_d;
`endif
                    end
                end
                ST_REQ: begin
                    if (mem_req_valid_q && mem_req_ready_i) begin
                        state_q         <= ST_RESP;
                        mem_req_valid_q <= 1'b0;
                    end
                end
                ST_RESP: begin
                    if (mem_rsp_valid_i) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q         <= ST_IDLE;
                    busy_q          <= 1'b0;
                    mem_req_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign if_req_ready_o  = grant_valid && !ls_wins;
    assign ls_req_ready_o  = grant_valid && ls_wins;

    assign if_rsp_valid_o  = rsp_fire && (owner_q == OWN_IF);
    assign ls_rsp_valid_o  = rsp_fire && (owner_q == OWN_LS);
    assign if_rdata_o      = if_rsp_valid_o ? mem_rdata_i : '0;
    assign ls_rdata_o      = ls_rsp_valid_o ? mem_rdata_i : '0;

    assign mem_req_valid_o = mem_req_valid_q;
    assign mem_addr_o      = addr_q;
    assign mem_wen_o       = wen_q;
    assign mem_wdata_o     = wdata_q;
    assign mem_wmask_o     = wmask_q;

    assign busy_o          = busy_q;
    assign err_spurious_o  = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; expected grant order follows MEM_ARBITER_RR_EN.
module tb_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        if_req_valid_i, if_req_ready_o, if_rsp_valid_o;
    logic [63:0] if_addr_i, if_rdata_o;
    logic        ls_req_valid_i, ls_req_ready_o, ls_wen_i, ls_rsp_valid_o;
    logic [63:0] ls_addr_i, ls_wdata_i, ls_rdata_o;
    logic [7:0]  ls_wmask_i, mem_wmask_o;
    logic        mem_req_valid_o, mem_req_ready_i, mem_wen_o, mem_rsp_valid_i;
    logic [63:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        busy_o, err_spurious_o;

    int total = 0;
    int bad   = 0;

    mem_arbiter dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .if_req_valid_i  (if_req_valid_i),
        .if_req_ready_o  (if_req_ready_o),
        .if_addr_i       (if_addr_i),
        .if_rsp_valid_o  (if_rsp_valid_o),
        .if_rdata_o      (if_rdata_o),
        .ls_req_valid_i  (ls_req_valid_i),
        .ls_req_ready_o  (ls_req_ready_o),
        .ls_addr_i       (ls_addr_i),
        .ls_wen_i        (ls_wen_i),
        .ls_wdata_i      (ls_wdata_i),
        .ls_wmask_i      (ls_wmask_i),
        .ls_rsp_valid_o  (ls_rsp_valid_o),
        .ls_rdata_o      (ls_rdata_o),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_addr_o      (mem_addr_o),
        .mem_wen_o       (mem_wen_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_wmask_o     (mem_wmask_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rdata_i     (mem_rdata_i),
        .busy_o          (busy_o),
        .err_spurious_o  (err_spurious_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic arb_txn(input int k, input logic exp_ls);
        #1;
        check($sformatf("arb%0d_if_ready", k), 64'(if_req_ready_o), 64'(!exp_ls));
        check($sformatf("arb%0d_ls_ready", k), 64'(ls_req_ready_o), 64'(exp_ls));
        step();
        mem_req_ready_i = 1'b1;
        #1;
        check($sformatf("arb%0d_addr", k), mem_addr_o, exp_ls ? 64'h200 : 64'h100);
        check($sformatf("arb%0d_ready_in_req", k), 64'(if_req_ready_o | ls_req_ready_o), 64'd0);
        step();
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b1;
        mem_rdata_i     = 64'(k) + 64'h50;
        #1;
        check($sformatf("arb%0d_if_rsp", k), 64'(if_rsp_valid_o), 64'(!exp_ls));
        check($sformatf("arb%0d_ls_rsp", k), 64'(ls_rsp_valid_o), 64'(exp_ls));
        check($sformatf("arb%0d_ready_in_resp", k), 64'(if_req_ready_o | ls_req_ready_o), 64'd0);
        step();
        mem_rsp_valid_i = 1'b0;
        mem_rdata_i     = '0;
    endtask

    initial begin
        logic [3:0] exp_ls_seq;
`ifdef MEM_ARBITER_RR_EN
        exp_ls_seq = 4'b1010;
`else
        exp_ls_seq = 4'b1111;
`endif
        rst_ni          = 1'b0;
        if_req_valid_i  = 1'b1;
        if_addr_i       = 64'h1234;
        ls_req_valid_i  = 1'b1;
        ls_addr_i       = '0;
        ls_wen_i        = 1'b0;
        ls_wdata_i      = '0;
        ls_wmask_i      = '0;
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b0;
        mem_rdata_i     = '0;

        // Reset: requests pending but every output must stay low.
        #12;
        check("rst_if_ready", 64'(if_req_ready_o), 64'd0);
        check("rst_ls_ready", 64'(ls_req_ready_o), 64'd0);
        check("rst_mem_valid", 64'(mem_req_valid_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_err", 64'(err_spurious_o), 64'd0);
        check("rst_addr", mem_addr_o, 64'd0);
        if_req_valid_i = 1'b0;
        ls_req_valid_i = 1'b0;
        #1 rst_ni = 1'b1;

        // Fetch-only read.
        step();
        if_req_valid_i = 1'b1;
        if_addr_i      = 64'h8000_0000;
        #1;
        check("f_if_ready", 64'(if_req_ready_o), 64'd1);
        check("f_ls_ready", 64'(ls_req_ready_o), 64'd0);
        step();
        if_req_valid_i  = 1'b0;
        mem_req_ready_i = 1'b1;
        #1;
        check("f_mem_valid", 64'(mem_req_valid_o), 64'd1);
        check("f_mem_addr", mem_addr_o, 64'h8000_0000);
        check("f_mem_wen", 64'(mem_wen_o), 64'd0);
        check("f_mem_wmask", 64'(mem_wmask_o), 64'd0);
        check("f_busy", 64'(busy_o), 64'd1);
        step();
        mem_req_ready_i = 1'b0;
        #1;
        check("f_wait_rsp", 64'(if_rsp_valid_o), 64'd0);
        check("f_mem_valid_drop", 64'(mem_req_valid_o), 64'd0);
        step();
        mem_rsp_valid_i = 1'b1;
        mem_rdata_i     = 64'h0010_0073_0000_0413;
        #1;
        check("f_if_rsp", 64'(if_rsp_valid_o), 64'd1);
        check("f_if_rdata", if_rdata_o, 64'h0010_0073_0000_0413);
        check("f_ls_rsp", 64'(ls_rsp_valid_o), 64'd0);
        check("f_ls_rdata", ls_rdata_o, 64'd0);
        step();
        mem_rsp_valid_i = 1'b0;
        mem_rdata_i     = '0;
        #1;
        check("f_if_rsp_once", 64'(if_rsp_valid_o), 64'd0);
        check("f_idle_busy", 64'(busy_o), 64'd0);

        // Load-store write with a 3-cycle memory stall.
        step();
        ls_req_valid_i = 1'b1;
        ls_wen_i       = 1'b1;
        ls_addr_i      = 64'h8000_1000;
        ls_wdata_i     = 64'hDEAD_BEEF;
        ls_wmask_i     = 8'h0F;
        #1;
        check("w_ls_ready", 64'(ls_req_ready_o), 64'd1);
        check("w_if_ready", 64'(if_req_ready_o), 64'd0);
        step();
        ls_req_valid_i = 1'b0;
        ls_wen_i       = 1'b0;
        ls_addr_i      = '0;
        ls_wdata_i     = '0;
        ls_wmask_i     = '0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("w_stall%0d_valid", i), 64'(mem_req_valid_o), 64'd1);
            check($sformatf("w_stall%0d_wen", i), 64'(mem_wen_o), 64'd1);
            check($sformatf("w_stall%0d_addr", i), mem_addr_o, 64'h8000_1000);
            check($sformatf("w_stall%0d_wdata", i), mem_wdata_o, 64'hDEAD_BEEF);
            check($sformatf("w_stall%0d_wmask", i), 64'(mem_wmask_o), 64'h0F);
            step();
        end
        mem_req_ready_i = 1'b1;
        #1;
        check("w_handshake_valid", 64'(mem_req_valid_o), 64'd1);
        step();
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b1;
        mem_rdata_i     = 64'h1234;
        #1;
        check("w_ls_ack", 64'(ls_rsp_valid_o), 64'd1);
        check("w_if_rsp", 64'(if_rsp_valid_o), 64'd0);
        check("w_if_rdata", if_rdata_o, 64'd0);
        step();
        mem_rsp_valid_i = 1'b0;
        mem_rdata_i     = '0;
        #1;
        check("w_ack_once", 64'(ls_rsp_valid_o), 64'd0);

        // Both ports request continuously for four transactions.
        step();
        if_req_valid_i = 1'b1;
        if_addr_i      = 64'h100;
        ls_req_valid_i = 1'b1;
        ls_addr_i      = 64'h200;
        for (int k = 0; k < 4; k++) begin
            arb_txn(k, exp_ls_seq[k]);
        end
        if_req_valid_i = 1'b0;
        ls_req_valid_i = 1'b0;

        // Spurious response in IDLE.
        #1;
        check("s_err_before", 64'(err_spurious_o), 64'd0);
        step();
        mem_rsp_valid_i = 1'b1;
        mem_rdata_i     = 64'hFFFF;
        #1;
        check("s_if_rsp", 64'(if_rsp_valid_o), 64'd0);
        check("s_ls_rsp", 64'(ls_rsp_valid_o), 64'd0);
        check("s_ls_rdata", ls_rdata_o, 64'd0);
        step();
        mem_rsp_valid_i = 1'b0;
        mem_rdata_i     = '0;
        #1;
        check("s_err_set", 64'(err_spurious_o), 64'd1);
        check("s_busy", 64'(busy_o), 64'd0);
        step();
        step();
        check("s_err_sticky", 64'(err_spurious_o), 64'd1);

        // Reset while in RESP, then a late response and a clean fetch.
        step();
        if_req_valid_i = 1'b1;
        if_addr_i      = 64'h8000_0000;
        step();
        if_req_valid_i  = 1'b0;
        mem_req_ready_i = 1'b1;
        step();
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b1;
        mem_rdata_i     = 64'hAAAA;
        #1;
        check("r_in_resp", 64'(if_rsp_valid_o), 64'd1);
        #1 rst_ni = 1'b0;
        if_req_valid_i = 1'b1;
        #1;
        check("r_if_rsp", 64'(if_rsp_valid_o), 64'd0);
        check("r_if_rdata", if_rdata_o, 64'd0);
        check("r_busy", 64'(busy_o), 64'd0);
        check("r_err_clear", 64'(err_spurious_o), 64'd0);
        check("r_mem_addr", mem_addr_o, 64'd0);
        check("r_if_ready", 64'(if_req_ready_o), 64'd0);
        if_req_valid_i = 1'b0;
        #1 rst_ni = 1'b1;
        #1;
        check("r_late_no_rsp", 64'(if_rsp_valid_o), 64'd0);
        step();
        mem_rsp_valid_i = 1'b0;
        mem_rdata_i     = '0;
        check("r_late_err", 64'(err_spurious_o), 64'd1);
        if_req_valid_i = 1'b1;
        #1;
        check("r2_if_ready", 64'(if_req_ready_o), 64'd1);
        step();
        if_req_valid_i  = 1'b0;
        mem_req_ready_i = 1'b1;
        #1;
        check("r2_mem_valid", 64'(mem_req_valid_o), 64'd1);
        step();
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b1;
        mem_rdata_i     = 64'h0010_0073_0000_0413;
        #1;
        check("r2_if_rsp", 64'(if_rsp_valid_o), 64'd1);
        check("r2_if_rdata", if_rdata_o, 64'h0010_0073_0000_0413);
        step();
        mem_rsp_valid_i = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 64, SHALL set the address width of all address ports.
REQ-002 Parameter DATA_W, default 64, SHALL set the data width; the mask width SHALL be DATA_W/8.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 rst  in  1  SHALL be the reset: asynchronous, active-low.
REQ-005 if_req_valid in 1 / if_req_ready out 1 / if_addr in ADDR_W SHALL form the fetch-requester read port.
REQ-006 if_rsp_valid out 1 / if_rdata out DATA_W SHALL return the fetch read data.
REQ-007 ls_req_valid in 1 / ls_req_ready out 1 / ls_addr in ADDR_W / ls_wen in 1 / ls_wdata in DATA_W / ls_wmask in DATA_W/8 SHALL form the load-store request port.
REQ-008 ls_rsp_valid out 1 / ls_rdata out DATA_W SHALL return load data or the write acknowledge.
REQ-009 mem_req_valid out 1 / mem_req_ready in 1 / mem_addr out ADDR_W / mem_wen out 1 / mem_wdata out DATA_W / mem_wmask out DATA_W/8 SHALL drive the shared memory port.
REQ-010 mem_rsp_valid in 1 / mem_rdata in DATA_W SHALL be the memory response.
REQ-011 busy out 1 SHALL be high whenever state is not IDLE.
REQ-012 err_spurious out 1 SHALL be a sticky flag for a memory response received outside RESP.

Function
REQ-013 The FSM SHALL have three states: IDLE, REQ, RESP. At most one transaction is outstanding.
REQ-014 IDLE: if any req_valid is high, the arbiter SHALL combinationally assert exactly one req_ready (the winner's), latch addr/wen/wdata/wmask and the owner, and go to REQ at the next edge.
REQ-015 Fetch requests SHALL be latched with wen=0 and wmask=0.
REQ-016 Both req_ready outputs SHALL be 0 in REQ and RESP.
REQ-017 REQ: mem_req_valid SHALL be 1 with the latched fields held stable; on mem_req_valid&&mem_req_ready the FSM SHALL go to RESP.
REQ-018 RESP: when mem_rsp_valid=1, the owner's rsp_valid SHALL be 1 in the same cycle, with rdata=mem_rdata. The FSM SHALL return to IDLE at the next edge.
REQ-019 The non-owner rsp_valid SHALL be 0 at all times. Both rdata outputs SHALL be 0 when their rsp_valid is 0.
REQ-020 Writes SHALL complete through RESP like reads. ls_rsp_valid acts as the write acknowledge. ls_rdata is don't-care for writes.
REQ-021 Minimum latency SHALL be: accept at cycle N, mem request at N+1, response at N+2 if the memory has zero wait.
REQ-022 A new request SHALL be accepted no earlier than the IDLE cycle following the response. There is no back-to-back bypass.
REQ-023 A mem_rsp_valid in IDLE or REQ SHALL be ignored for routing and SHALL set err_spurious. err_spurious is cleared only by reset.
REQ-024 A requester dropping valid before acceptance SHALL cancel its request with no side effect.
REQ-025 last_grant SHALL record the owner of each accepted request, for round-robin use.

Reset
REQ-026 rst low SHALL immediately force state=IDLE, last_grant=LS, err_spurious=0, and all latched fields to 0.
REQ-027 During reset every output SHALL be 0.
REQ-028 A reset in REQ or RESP SHALL drop the transaction without any response. A late mem_rsp_valid after reset release SHALL set err_spurious.

Configuration
REQ-029 Macro MEM_ARBITER_RR_EN defined: on a simultaneous request, the requester not equal to last_grant SHALL win. The first conflict after reset is therefore won by the fetch port.
REQ-030 Macro MEM_ARBITER_RR_EN undefined: on a simultaneous request, LS SHALL always win, and last_grant SHALL be unused.

Verification
REQ-031 Fetch-only read, if_addr=0x80000000, memory returns 0x00100073_00000413 two cycles after mem_req_ready -> if_rsp_valid pulses once with that data; ls_rsp_valid stays 0.
REQ-032 LS write, addr=0x80001000, wdata=0xDEADBEEF, wmask=0x0F -> mem_wen=1 with identical fields held through a 3-cycle mem_req_ready stall; then ls_rsp_valid pulses once.
REQ-033 Both ports requesting on consecutive transactions -> with RR_EN the grants go IF, LS, IF, LS; without it they go LS, LS, ... while LS stays valid.
REQ-034 mem_rsp_valid pulsed in IDLE -> no rsp_valid is asserted; err_spurious=1 and stays 1 until rst is low.
REQ-035 rst asserted low while in RESP -> all outputs 0 immediately; after release a new fetch completes normally.
